// File: rtl/run_stats_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : run_stats_pkg
//  Brief    : Shared state encoding, default counter width and limit helper
//             for the run-statistics unit.
//  Revision : 1.0 - initial release
// ============================================================================
package run_stats_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // All-ones value for a counter of the given width (capped at 64 bits).
    function automatic logic [63:0] cnt_limit(input int width);
        if (width >= 64) return '1;
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_stats_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : run_stats_counter_if
//  Brief    : CPU retire-side signals observed by the run-statistics unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface run_stats_counter_if;

    logic instr_valid;
    logic is_jump;
    logic is_branch;
    logic branch_taken;
    logic is_halt;

    modport master (
        output instr_valid, is_jump, is_branch, branch_taken, is_halt
    );

    modport slave (
        input  instr_valid, is_jump, is_branch, branch_taken, is_halt
    );

endinterface
`default_nettype wire

// File: rtl/run_stats_counter_stat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : stat_counter
//  Brief    : Single event counter with synchronous clear and selectable
//             saturate-at-all-ones or modulo wrap behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module stat_counter
    import run_stats_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             inc,
    input  wire logic             sat,
    output logic [CNT_W-1:0]      count
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(cnt_limit(CNT_W));

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && !(sat && (r_count == c_max))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/run_stats_counter.sv
`default_nettype none
// ============================================================================
//  Module   : run_stats_counter
//  Brief    : Run statistics (cycles, retires, jumps, branches, stalls) for
//             the trace logger; counts only between go and halt retire.
//             Optional stall counter enabled by RUN_STATS_STALL_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module run_stats_counter
    import run_stats_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEFAULT,
    parameter int SAT_EN_DEFAULT = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          go,
    input  wire logic          clr,
    run_stats_counter_if.slave ret,
    output logic [CNT_W-1:0]   cy,
    output logic [CNT_W-1:0]   jm,
    output logic [CNT_W-1:0]   cj,
    output logic [CNT_W-1:0]   cn,
    output logic [CNT_W-1:0]   ic,
    output logic [CNT_W-1:0]   st,
    output logic               running,
    output logic               halted
);

    state_t r_state;
    state_t w_state_nxt;

    logic w_sat;
    logic w_run;
    logic w_ret;
    logic w_br;

    assign w_sat = (SAT_EN_DEFAULT != 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (go) w_state_nxt = RUN;
            RUN:     if (ret.instr_valid && ret.is_halt) w_state_nxt = HALT;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
        endcase
        if (clr) w_state_nxt = IDLE;
    end

    assign running = (r_state == RUN);
    assign halted  = (r_state == HALT);

    // Counting is gated purely by state, so IDLE/HALT events fall away and
    // the halt-retire cycle itself is still counted.
    assign w_run = running;
    assign w_ret = w_run && ret.instr_valid;
    // A jump flagged as a branch too is a protocol error: count the jump only.
    assign w_br  = w_ret && ret.is_branch && !ret.is_jump;

    stat_counter #(.CNT_W(CNT_W)) u_cy (
        .clk(clk), .rst(rst), .clr(clr), .inc(w_run), .sat(w_sat), .count(cy)
    );
    stat_counter #(.CNT_W(CNT_W)) u_ic (
        .clk(clk), .rst(rst), .clr(clr), .inc(w_ret), .sat(w_sat), .count(ic)
    );
    stat_counter #(.CNT_W(CNT_W)) u_jm (
        .clk(clk), .rst(rst), .clr(clr), .inc(w_ret && ret.is_jump),
        .sat(w_sat), .count(jm)
    );
    stat_counter #(.CNT_W(CNT_W)) u_cj (
        .clk(clk), .rst(rst), .clr(clr), .inc(w_br && ret.branch_taken),
        .sat(w_sat), .count(cj)
    );
    stat_counter #(.CNT_W(CNT_W)) u_cn (
        .clk(clk), .rst(rst), .clr(clr), .inc(w_br && !ret.branch_taken),
        .sat(w_sat), .count(cn)
    );

`ifdef RUN_STATS_STALL_CNT_EN
    stat_counter #(.CNT_W(CNT_W)) u_st (
        .clk(clk), .rst(rst), .clr(clr), .inc(w_run && !ret.instr_valid),
        .sat(w_sat), .count(st)
    );
`else
    assign st = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_stats_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_stats_counter
//  Brief    : Self-checking bench; a 32-bit saturating, a 4-bit saturating and
//             a 4-bit wrapping instance share one stimulus stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_run_stats_counter;

    localparam int ND = 3;
    localparam int NC = 6;  // cy, jm, cj, cn, ic, st
`ifdef RUN_STATS_STALL_CNT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic go  = 1'b0;
    logic clr = 1'b0;

    run_stats_counter_if bus ();

    logic [31:0] cy0, jm0, cj0, cn0, ic0, st0;
    logic [3:0]  cy1, jm1, cj1, cn1, ic1, st1;
    logic [3:0]  cy2, jm2, cj2, cn2, ic2, st2;
    logic        run0, run1, run2, hlt0, hlt1, hlt2;

    run_stats_counter #(.CNT_W(32), .SAT_EN_DEFAULT(1)) dut (
        .clk(clk), .rst(rst), .go(go), .clr(clr), .ret(bus),
        .cy(cy0), .jm(jm0), .cj(cj0), .cn(cn0), .ic(ic0), .st(st0),
        .running(run0), .halted(hlt0)
    );
    run_stats_counter #(.CNT_W(4), .SAT_EN_DEFAULT(1)) dut4s (
        .clk(clk), .rst(rst), .go(go), .clr(clr), .ret(bus),
        .cy(cy1), .jm(jm1), .cj(cj1), .cn(cn1), .ic(ic1), .st(st1),
        .running(run1), .halted(hlt1)
    );
    run_stats_counter #(.CNT_W(4), .SAT_EN_DEFAULT(0)) dut4w (
        .clk(clk), .rst(rst), .go(go), .clr(clr), .ret(bus),
        .cy(cy2), .jm(jm2), .cj(cj2), .cn(cn2), .ic(ic2), .st(st2),
        .running(run2), .halted(hlt2)
    );

    always #5 clk = ~clk;

    logic [31:0] act [ND][NC];
    logic        act_run [ND];
    logic        act_hlt [ND];

    always_comb begin
        act[0][0] = cy0; act[0][1] = jm0; act[0][2] = cj0;
        act[0][3] = cn0; act[0][4] = ic0; act[0][5] = st0;
        act[1][0] = {28'd0, cy1}; act[1][1] = {28'd0, jm1}; act[1][2] = {28'd0, cj1};
        act[1][3] = {28'd0, cn1}; act[1][4] = {28'd0, ic1}; act[1][5] = {28'd0, st1};
        act[2][0] = {28'd0, cy2}; act[2][1] = {28'd0, jm2}; act[2][2] = {28'd0, cj2};
        act[2][3] = {28'd0, cn2}; act[2][4] = {28'd0, ic2}; act[2][5] = {28'd0, st2};
        act_run[0] = run0; act_run[1] = run1; act_run[2] = run2;
        act_hlt[0] = hlt0; act_hlt[1] = hlt1; act_hlt[2] = hlt2;
    end

    int    errors = 0;
    int    checks = 0;
    string cname [NC] = '{"cy", "jm", "cj", "cn", "ic", "st"};
    int    dw    [ND] = '{32, 4, 4};
    bit    dsat  [ND] = '{1'b1, 1'b1, 1'b0};

    // Reference model: unbounded event tallies plus a run phase flag.
    longint unsigned m_cnt [NC];
    bit m_running = 1'b0;
    bit m_halted  = 1'b0;

    function automatic longint unsigned expv(int d, int k);
        longint unsigned lim;
        longint unsigned n;
        if (k == 5 && !STALL_ON) return 0;
        lim = (64'd1 << dw[d]) - 64'd1;
        n   = m_cnt[k];
        if (dsat[d]) return (n > lim) ? lim : n;
        return n % (lim + 64'd1);
    endfunction

    task automatic model_step(input bit g, c, v, j, b, t, h);
        if (rst || c) begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_running = 1'b0;
            m_halted  = 1'b0;
        end else if (m_running) begin
            m_cnt[0]++;
            if (v) begin
                m_cnt[4]++;
                if (j)      m_cnt[1]++;
                else if (b) m_cnt[t ? 2 : 3]++;
                if (h) begin
                    m_running = 1'b0;
                    m_halted  = 1'b1;
                end
            end else begin
                m_cnt[5]++;
            end
        end else if (!m_halted && g) begin
            m_running = 1'b1;
        end
    endtask

    task automatic cycle(input bit g, c, v, j, b, t, h);
        go = g; clr = c;
        bus.instr_valid = v; bus.is_jump = j; bus.is_branch = b;
        bus.branch_taken = t; bus.is_halt = h;
        @(posedge clk);
        model_step(g, c, v, j, b, t, h);
        #1;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycle();
        idle_cycle();
        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < NC; k++) begin
                checks++;
                if (act[d][k] !== 32'd0) begin
                    errors++;
                    $display("FAIL reset dut%0d %s: got %0d expected 0", d, cname[k], act[d][k]);
                end
            end
            checks++;
            if (act_run[d] !== 1'b0 || act_hlt[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d status: running=%b halted=%b expected 0/0", d, act_run[d], act_hlt[d]);
            end
        end
    endtask

    task automatic test_basic_halt();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (cy0 !== 32'd11 || ic0 !== 32'd11 || jm0 !== 0 || cj0 !== 0 || cn0 !== 0 || hlt0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_halt: cy=%0d ic=%0d jm=%0d cj=%0d cn=%0d halted=%b expected 11 11 0 0 0 1",
                     cy0, ic0, jm0, cj0, cn0, hlt0);
        end
        // Anything on the retire bus, including go, must leave HALT frozen.
        for (int i = 0; i < 20; i++)
            cycle(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        checks++;
        if (cy0 !== 32'd11 || ic0 !== 32'd11 || hlt0 !== 1'b1 || run0 !== 1'b0) begin
            errors++;
            $display("FAIL halt_frozen: cy=%0d ic=%0d halted=%b running=%b expected 11 11 1 0",
                     cy0, ic0, hlt0, run0);
        end
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < NC; k++) begin
                checks++;
                if (act[d][k] !== 32'(expv(d, k))) begin
                    errors++;
                    $display("FAIL halt_model dut%0d %s: got %0d expected %0d", d, cname[k], act[d][k], expv(d, k));
                end
            end
        end
    endtask

    task automatic test_mix();
        int kinds [9] = '{0, 1, 2, 1, 2, 2, 0, 2, 0}; // 0 jump, 1 taken, 2 not-taken
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        foreach (kinds[i])
            cycle(1'b0, 1'b0, 1'b1, kinds[i] == 0, kinds[i] != 0, kinds[i] == 1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (jm0 !== 32'd3 || cj0 !== 32'd2 || cn0 !== 32'd4 || ic0 !== 32'd10 || cy0 !== 32'd10) begin
            errors++;
            $display("FAIL mix: jm=%0d cj=%0d cn=%0d ic=%0d cy=%0d expected 3 2 4 10 10", jm0, cj0, cn0, ic0, cy0);
        end
    endtask

    task automatic test_idle_ignored();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < NC; k++) begin
                checks++;
                if (act[d][k] !== 32'd0) begin
                    errors++;
                    $display("FAIL idle dut%0d %s: got %0d expected 0", d, cname[k], act[d][k]);
                end
            end
        end
        checks++;
        if (run0 !== 1'b0 || hlt0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_status: running=%b halted=%b expected 0 0", run0, hlt0);
        end
    endtask

    task automatic test_clr_go_in_halt();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 49; i++) cycle(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (cy0 !== 32'd50 || cy1 !== 4'd15 || cy2 !== 4'd2 || hlt0 !== 1'b1) begin
            errors++;
            $display("FAIL pre_clr: cy32=%0d cy4s=%0d cy4w=%0d halted=%b expected 50 15 2 1", cy0, cy1, cy2, hlt0);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cy0 !== 0 || ic0 !== 0 || jm0 !== 0 || run0 !== 1'b0 || hlt0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_go: cy=%0d ic=%0d jm=%0d running=%b halted=%b expected 0 0 0 0 0",
                     cy0, ic0, jm0, run0, hlt0);
        end
    endtask

    task automatic test_saturation();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cy1 !== 4'd15 || cy2 !== 4'd4 || cy0 !== 32'd20 || ic1 !== 4'd15 || ic2 !== 4'd4) begin
            errors++;
            $display("FAIL saturation: cy4s=%0d cy4w=%0d cy32=%0d ic4s=%0d ic4w=%0d expected 15 4 20 15 4",
                     cy1, cy2, cy0, ic1, ic2);
        end
    endtask

    task automatic test_stall();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, (i % 3) == 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ic0 !== 32'd4 || cy0 !== 32'd12 || st0 !== (STALL_ON ? 32'd8 : 32'd0)) begin
            errors++;
            $display("FAIL stall: ic=%0d st=%0d cy=%0d expected 4 %0d 12", ic0, st0, cy0, STALL_ON ? 8 : 0);
        end
    endtask

    task automatic test_reset_midrun();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checks++;
        if (cy0 !== 0 || jm0 !== 0 || ic0 !== 0 || run0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: cy=%0d jm=%0d ic=%0d running=%b expected 0 0 0 0", cy0, jm0, ic0, run0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 40) == 0));
            for (int d = 0; d < ND; d++) begin
                for (int k = 0; k < NC; k++) begin
                    checks++;
                    if (act[d][k] !== 32'(expv(d, k))) begin
                        errors++;
                        $display("FAIL random c%0d dut%0d %s: got %0d expected %0d", i, d, cname[k], act[d][k], expv(d, k));
                    end
                end
                checks++;
                if (act_run[d] !== m_running || act_hlt[d] !== m_halted) begin
                    errors++;
                    $display("FAIL random c%0d dut%0d status: running=%b halted=%b expected %b %b",
                             i, d, act_run[d], act_hlt[d], m_running, m_halted);
                end
            end
        end
    endtask

    initial begin
        bus.instr_valid = 1'b0; bus.is_jump = 1'b0; bus.is_branch = 1'b0;
        bus.branch_taken = 1'b0; bus.is_halt = 1'b0;
        test_reset();
        test_basic_halt();
        test_mix();
        test_idle_ignored();
        test_clr_go_in_halt();
        test_saturation();
        test_stall();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_stats_counter.md
Name: run_stats_counter

Overview:
- Synthesizable run-statistics unit that sits directly upstream of the simulation trace logger.
- Watches the CPU retire interface and produces the counts the logger consumes:
  - cycle count (cy)
  - unconditional jump count (jm)
  - taken conditional-branch count (cj)
- Also produces retired-instruction count, not-taken branch count and run/halt status.
- Counting starts on a go pulse. It freezes when the halt instruction (syscall) retires, so the logger's end-of-run check sees a stable final cycle value.

Parameters:
- CNT_W, 32, width of every counter output.
- SAT_EN_DEFAULT, 1, 1 = counters saturate at all-ones; 0 = counters wrap modulo 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start pulse; sampled only in IDLE.
- clr  in  1  synchronous clear; returns to IDLE with all counters zero.
- instr_valid  in  1  one instruction retires this cycle.
- is_jump  in  1  retiring instruction is j/jal/jr; qualified by instr_valid.
- is_branch  in  1  retiring instruction is beq/bne; qualified by instr_valid.
- branch_taken  in  1  branch condition true; qualified by instr_valid & is_branch.
- is_halt  in  1  retiring instruction is the halt syscall; qualified by instr_valid.
- cy  out  CNT_W  cycles spent in RUN, including the halt cycle.
- jm  out  CNT_W  retired unconditional jumps.
- cj  out  CNT_W  retired taken conditional branches.
- cn  out  CNT_W  retired not-taken conditional branches.
- ic  out  CNT_W  retired instructions.
- st  out  CNT_W  stall cycles (see Optional Feature).
- running  out  1  state == RUN.
- halted  out  1  state == HALT.

Behaviour:
- Reset: state=IDLE; all counters 0; running=0; halted=0.
- States:
  - IDLE -> RUN when go=1.
  - RUN -> HALT when instr_valid & is_halt.
  - HALT is sticky; it is left only by clr or rst.
- clr in any state: next state IDLE, all counters 0. clr has priority over go and over any retire in the same cycle.
- rst has priority over everything. Reset mid-RUN discards all counts.
- Counting is done only in RUN; events in IDLE or HALT are ignored.
- Per RUN cycle (all updates registered, outputs change the cycle after the event, 1-cycle latency):
  - cy += 1 every RUN cycle.
  - ic += 1 if instr_valid.
  - jm += 1 if instr_valid & is_jump.
  - cj += 1 if instr_valid & is_branch & branch_taken.
  - cn += 1 if instr_valid & is_branch & ~branch_taken.
- The halt-retire cycle is counted in cy and ic, and its jump/branch flags are also honoured. From the following cycle every counter is frozen.
- is_jump and is_branch both set: treat as protocol error; count jump only (jm), not cj/cn.
- go in the same cycle as the transition into RUN counts nothing; the first counted cycle is the one after go.
- go while in RUN or HALT: ignored.
- Boundary at all-ones:
  - SAT_EN_DEFAULT=1: counter holds at all-ones.
  - SAT_EN_DEFAULT=0: counter wraps to 0.
- Outputs are stable while in HALT, so a downstream consumer can sample them at any time after halted rises.

Optional Feature:
- Macro RUN_STATS_STALL_CNT_EN.
- Defined: st += 1 on each RUN cycle with instr_valid=0, with the same saturation/wrap rule as the other counters. Invariant: st + ic == cy.
- Undefined: st is tied to 0 and no stall counter register is instantiated. The port remains, so the interface is unchanged.

Decomposition:
- Package run_stats_pkg holds:
  - state enum {IDLE, RUN, HALT} (2-bit encoding)
  - CNT_W default constant
  - helper function for the all-ones limit
- One natural sub-module, stat_counter. Inputs: clk, rst, clr, inc, sat. Output: count. Instantiated six times (five when the feature is off).

Test Plan:
- Reset, then go at cycle 0. Run 10 cycles with instr_valid=1 and no flags, then retire is_halt. Result: cy=11, ic=11, jm=cj=cn=0, halted=1; all values unchanged 20 cycles later.
- Inside a RUN, retire 3 jumps, 2 taken branches and 4 not-taken branches, then halt. Result: jm=3, cj=2, cn=4, ic=10.
- Retire instructions while in IDLE (no go) for 8 cycles. Result: all counters 0, running=0.
- Assert clr and go together while in HALT with cy=50. Result: next cycle IDLE, all counters 0; go is ignored.
- CNT_W=4, SAT_EN_DEFAULT=1, 20 RUN cycles. Result: cy=15. Repeat with SAT_EN_DEFAULT=0. Result: cy=4.
- With RUN_STATS_STALL_CNT_EN defined, 12 RUN cycles with instr_valid pattern 1,0,0 repeating. Result: ic=4, st=8, cy=12. With the macro undefined, st=0 throughout.
